// File: rtl/sample_acc_pkg.sv
// -----------------------------------------------------------------------------
// sample_acc_pkg
// Shared definitions for the signed accumulate-and-saturate stage:
//   - default width / depth constants
//   - FSM state encoding
//   - sat(): clamps a wide signed value into a narrower signed range and
//     reports whether clipping occurred
// -----------------------------------------------------------------------------
package sample_acc_pkg;

   localparam int DIN_WIDTH_DEF   = 11;
   localparam int ACC_WIDTH_DEF   = 24;
   localparam int DOUT_WIDTH_DEF  = 12;
   localparam int N_TERMS_DEF     = 16;
   localparam int MUL_LATENCY_DEF = 2;

   // sat() works on a fixed wide container so one function serves any
   // ACC_WIDTH / DOUT_WIDTH combination up to this width.
   localparam int SAT_W = 64;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_ACC  = 1'b1
   } acc_state_e;

   typedef struct packed {
      logic signed [SAT_W-1:0] value;
      logic                    clip;
   } sat_res_t;

   // Clamp val to [-2^(dout_w-1), 2^(dout_w-1)-1]. The caller keeps the low
   // dout_w bits of .value, which are exact once the clamp has been applied.
   function automatic sat_res_t sat(input logic signed [SAT_W-1:0] val,
                                    input int                      dout_w);
      logic signed [SAT_W-1:0] max_v;
      logic signed [SAT_W-1:0] min_v;
      sat_res_t                res;
      max_v = (64'sd1 <<< (dout_w - 1)) - 64'sd1;
      min_v = ~max_v;
      if (val > max_v) begin
         res.value = max_v;
         res.clip  = 1'b1;
      end else if (val < min_v) begin
         res.value = min_v;
         res.clip  = 1'b1;
      end else begin
         res.value = val;
         res.clip  = 1'b0;
      end
      return res;
   endfunction

endpackage

// File: rtl/sample_acc_vld_dly.sv
// -----------------------------------------------------------------------------
// sample_acc_vld_dly
// Shift register that carries the {valid, last} operand tags alongside the
// multiplier pipeline so the tail lines up with the product on din.
// Advances only while en_i is high, so it freezes together with the
// multiplier.
//
// Ports
//   clk      rising-edge clock
//   clr_n_i  synchronous active-low clear of all stages
//   en_i     shift enable (multiplier ce)
//   valid_i  operand pair presented this cycle
//   last_i   final term of the vector (qualified by valid_i)
//   valid_o  tail valid, aligned with the product
//   last_o   tail last, aligned with the product
// -----------------------------------------------------------------------------
module sample_acc_vld_dly #(
   parameter int LATENCY = 2
) (
   input  logic clk,
   input  logic clr_n_i,
   input  logic en_i,
   input  logic valid_i,
   input  logic last_i,
   output logic valid_o,
   output logic last_o
);

   logic [LATENCY-1:0] valid_q;
   logic [LATENCY-1:0] last_q;

   always_ff @(posedge clk) begin
      if (!clr_n_i) begin
         valid_q <= '0;
         last_q  <= '0;
      end else if (en_i) begin
         valid_q[0] <= valid_i;
         // last is meaningless without valid; masking here keeps the tail
         // clean so downstream never has to re-qualify it
         last_q[0]  <= last_i & valid_i;
         for (int i = 1; i < LATENCY; i++) begin
            valid_q[i] <= valid_q[i-1];
            last_q[i]  <= last_q[i-1];
         end
      end
   end

   assign valid_o = valid_q[LATENCY-1];
   assign last_o  = last_q[LATENCY-1];

endmodule

// File: rtl/sample_acc_sat.sv
// -----------------------------------------------------------------------------
// sample_acc_sat
// Sums a vector of signed products from the upstream multiplier into a dot
// product, saturates it to DOUT_WIDTH and presents it on a valid/ready port.
// Owns the multiplier ce so output backpressure stalls multiplier, tag delay
// line and accumulator together.
//
// State table
//   state  | meaning
//   S_IDLE | no partial sum; next valid term starts a new vector
//   S_ACC  | partial sum in acc_q, cnt_q terms accumulated so far
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   in_valid    operand pair presented to the multiplier this cycle
//   in_last     final term of the vector (qualified by in_valid)
//   din         signed product from the multiplier
//   ce_out      multiplier ce / upstream ready (combinational from dout_ready)
//   dout        saturated dot-product result
//   dout_valid  dout holds an unconsumed result
//   dout_ready  downstream accepts dout
//   overflow    current dout was clipped
//   len_err     current dout was force-closed at N_TERMS without in_last
// -----------------------------------------------------------------------------
module sample_acc_sat
   import sample_acc_pkg::*;
#(
   parameter int DIN_WIDTH   = DIN_WIDTH_DEF,
   parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
   parameter int DOUT_WIDTH  = DOUT_WIDTH_DEF,
   parameter int N_TERMS     = N_TERMS_DEF,
   parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic                         in_last,
   input  logic signed [DIN_WIDTH-1:0]  din,
   output logic                         ce_out,
   output logic signed [DOUT_WIDTH-1:0] dout,
   output logic                         dout_valid,
   input  logic                         dout_ready,
   output logic                         overflow,
   output logic                         len_err
);

   // Wide enough to hold N_TERMS itself, not just N_TERMS-1.
   localparam int              CNT_W   = $clog2(N_TERMS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_TERMS);

   acc_state_e                  state_q, state_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;

   logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
   logic                         dout_valid_q, dout_valid_d;
   logic                         overflow_q, overflow_d;
   logic                         len_err_q, len_err_d;

   logic                         t_valid;
   logic                         t_last;
   logic                         take;
   logic                         close;
   logic signed [ACC_WIDTH-1:0]  din_ext;
   logic signed [ACC_WIDTH-1:0]  acc_sum;
   logic [CNT_W-1:0]             cnt_sum;
   sat_res_t                     sat_r;
   logic                         unused_sat_hi;

   assign ce_out = ~dout_valid_q | dout_ready;

   sample_acc_vld_dly #(
      .LATENCY (MUL_LATENCY)
   ) u_vld_dly (
      .clk     (clk),
      .clr_n_i (reset),
      .en_i    (ce_out),
      .valid_i (in_valid),
      .last_i  (in_last),
      .valid_o (t_valid),
      .last_o  (t_last)
   );

   // Sum and count as they will be after the tail term is absorbed; the
   // close decision and the saturated result both use these, so the closing
   // term is always included.
   assign din_ext = ACC_WIDTH'(din);
   assign acc_sum = (state_q == S_IDLE) ? din_ext : acc_q + din_ext;
   assign cnt_sum = (state_q == S_IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);

   assign take  = ce_out & t_valid;
   assign close = take & (t_last | (cnt_sum == CNT_MAX));

   assign sat_r         = sat(SAT_W'(acc_sum), DOUT_WIDTH);
   assign unused_sat_hi = ^sat_r.value[SAT_W-1:DOUT_WIDTH];

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      dout_d       = dout_q;
      overflow_d   = overflow_q;
      len_err_d    = len_err_q;
      // A consumed result drops valid; a close on the same edge re-raises it
      // below, which is what makes back-to-back results bubble-free.
      dout_valid_d = dout_valid_q & ~dout_ready;

      if (take) begin
         if (close) begin
            state_d      = S_IDLE;
            acc_d        = '0;
            cnt_d        = '0;
            dout_d       = sat_r.value[DOUT_WIDTH-1:0];
            dout_valid_d = 1'b1;
            overflow_d   = sat_r.clip;
            len_err_d    = ~t_last;
         end else begin
            state_d = S_ACC;
            acc_d   = acc_sum;
            cnt_d   = cnt_sum;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         acc_q        <= '0;
         cnt_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         len_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overflow_q   <= overflow_d;
         len_err_q    <= len_err_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign overflow   = overflow_q;
   assign len_err    = len_err_q;

endmodule

// File: tb/tb_sample_acc_sat.sv
// -----------------------------------------------------------------------------
// tb_sample_acc_sat
// Directed bench for sample_acc_sat with default parameters. A two-stage
// ce-gated pipeline stands in for the multiplier: the bench presents the
// desired product as the "operand" and it reaches din MUL_LATENCY edges later.
// -----------------------------------------------------------------------------
module tb_sample_acc_sat;

   logic                clk;
   logic                reset;
   logic                in_valid;
   logic                in_last;
   logic signed [10:0]  din;
   logic                ce_out;
   logic signed [11:0]  dout;
   logic                dout_valid;
   logic                dout_ready;
   logic                overflow;
   logic                len_err;

   logic signed [10:0]  op;
   logic signed [10:0]  p1;
   logic signed [10:0]  p2;

   int n_cmp;
   int n_err;

   sample_acc_sat dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .din        (din),
      .ce_out     (ce_out),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .overflow   (overflow),
      .len_err    (len_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // multiplier stand-in, frozen by ce exactly like the real one
   always @(posedge clk) begin
      if (ce_out) begin
         p1 <= op;
         p2 <= p1;
      end
   end
   assign din = p2;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_term(input int val, input bit last);
      int guard;
      @(negedge clk);
      in_valid = 1'b1;
      in_last  = last;
      op       = 11'(val);
      guard    = 0;
      while (!ce_out && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (dout_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (dout !== 12'sd0) begin n_err++; $display("FAIL reset_dout: got %0d expected 0", dout); end
      n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_dout_valid: got %b expected 0", dout_valid); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL reset_len_err: got %b expected 0", len_err); end
      n_cmp++; if (ce_out !== 1'b1) begin n_err++; $display("FAIL reset_ce_out: got %b expected 1", ce_out); end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      dout_ready = 1'b1;
      drive_term(3, 0);
      drive_term(-5, 0);
      drive_term(7, 0);
      drive_term(10, 1);
      idle();
      n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL basic_lat0: got %b expected 0", dout_valid); end
      @(negedge clk);
      n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL basic_lat1: got %b expected 0", dout_valid); end
      @(negedge clk);
      n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL basic_lat2: got %b expected 1", dout_valid); end
      n_cmp++; if (dout !== 12'sd15) begin n_err++; $display("FAIL basic_dout: got %0d expected 15", dout); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL basic_overflow: got %b expected 0", overflow); end
      n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL basic_len_err: got %b expected 0", len_err); end
      @(negedge clk);
      n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL basic_consumed: got %b expected 0", dout_valid); end
   endtask

   task automatic test_saturation();
      bit ok;
      dout_ready = 1'b1;
      for (int i = 0; i < 16; i++) drive_term(1023, i == 15);
      idle();
      wait_valid(ok);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL sat_pos_timeout: got valid %b expected 1", ok); end
      n_cmp++; if (dout !== 12'sd2047) begin n_err++; $display("FAIL sat_pos_dout: got %0d expected 2047", dout); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL sat_pos_overflow: got %b expected 1", overflow); end
      n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL sat_pos_len_err: got %b expected 0", len_err); end
      for (int i = 0; i < 16; i++) drive_term(-1024, i == 15);
      idle();
      wait_valid(ok);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL sat_neg_timeout: got valid %b expected 1", ok); end
      n_cmp++; if (dout !== 12'h800) begin n_err++; $display("FAIL sat_neg_dout: got %0d expected -2048", dout); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL sat_neg_overflow: got %b expected 1", overflow); end
      @(negedge clk);
   endtask

   task automatic test_len_err();
      bit ok;
      dout_ready = 1'b1;
      for (int i = 0; i < 16; i++) drive_term(1, 0);
      idle();
      wait_valid(ok);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL len_first_timeout: got valid %b expected 1", ok); end
      n_cmp++; if (dout !== 12'sd16) begin n_err++; $display("FAIL len_first_dout: got %0d expected 16", dout); end
      n_cmp++; if (len_err !== 1'b1) begin n_err++; $display("FAIL len_first_len_err: got %b expected 1", len_err); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL len_first_overflow: got %b expected 0", overflow); end
      for (int i = 0; i < 4; i++) drive_term(1, i == 3);
      idle();
      wait_valid(ok);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL len_second_timeout: got valid %b expected 1", ok); end
      n_cmp++; if (dout !== 12'sd4) begin n_err++; $display("FAIL len_second_dout: got %0d expected 4", dout); end
      n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL len_second_len_err: got %b expected 0", len_err); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      bit ok;
      dout_ready = 1'b0;
      drive_term(1, 0);
      drive_term(2, 1);
      drive_term(5, 1);
      idle();
      wait_valid(ok);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL bp_first_timeout: got valid %b expected 1", ok); end
      n_cmp++; if (dout !== 12'sd3) begin n_err++; $display("FAIL bp_first_dout: got %0d expected 3", dout); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++; if (ce_out !== 1'b0) begin n_err++; $display("FAIL bp_stall_ce_out[%0d]: got %b expected 0", i, ce_out); end
         n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL bp_stall_valid[%0d]: got %b expected 1", i, dout_valid); end
         n_cmp++; if (dout !== 12'sd3) begin n_err++; $display("FAIL bp_stall_dout[%0d]: got %0d expected 3", i, dout); end
      end
      dout_ready = 1'b1;
      #1;
      n_cmp++; if (ce_out !== 1'b1) begin n_err++; $display("FAIL bp_release_ce_out: got %b expected 1", ce_out); end
      @(negedge clk);
      n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL bp_second_valid: got %b expected 1", dout_valid); end
      n_cmp++; if (dout !== 12'sd5) begin n_err++; $display("FAIL bp_second_dout: got %0d expected 5", dout); end
      @(negedge clk);
      n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_dup: got %b expected 0", dout_valid); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      dout_ready = 1'b1;
      drive_term(9, 1);
      drive_term(-2, 1);
      idle();
      wait_valid(ok);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_timeout: got valid %b expected 1", ok); end
      n_cmp++; if (dout !== 12'sd9) begin n_err++; $display("FAIL b2b_first_dout: got %0d expected 9", dout); end
      @(negedge clk);
      n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second_valid: got %b expected 1", dout_valid); end
      n_cmp++; if (dout !== -12'sd2) begin n_err++; $display("FAIL b2b_second_dout: got %0d expected -2", dout); end
      @(negedge clk);
      n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end_valid: got %b expected 0", dout_valid); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      dout_ready = 1'b1;
      drive_term(100, 0);
      drive_term(200, 0);
      drive_term(300, 0);
      @(negedge clk);
      reset      = 1'b0;
      in_valid   = 1'b0;
      in_last    = 1'b0;
      dout_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (dout !== 12'sd0) begin n_err++; $display("FAIL rstmid_dout: got %0d expected 0", dout); end
      n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b expected 0", dout_valid); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rstmid_overflow: got %b expected 0", overflow); end
      n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL rstmid_len_err: got %b expected 0", len_err); end
      n_cmp++; if (ce_out !== 1'b1) begin n_err++; $display("FAIL rstmid_ce_out: got %b expected 1", ce_out); end
      @(negedge clk);
      reset      = 1'b1;
      dout_ready = 1'b1;
      drive_term(4, 1);
      idle();
      wait_valid(ok);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rstmid_timeout: got valid %b expected 1", ok); end
      n_cmp++; if (dout !== 12'sd4) begin n_err++; $display("FAIL rstmid_after_dout: got %0d expected 4", dout); end
      n_cmp++; if (len_err !== 1'b0) begin n_err++; $display("FAIL rstmid_after_len_err: got %b expected 0", len_err); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rstmid_after_overflow: got %b expected 0", overflow); end
      @(negedge clk);
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      reset      = 1'b0;
      in_valid   = 1'b0;
      in_last    = 1'b0;
      op         = '0;
      dout_ready = 1'b1;
      test_reset();
      test_basic();
      test_saturation();
      test_len_err();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sample_acc_sat.md
# sample_acc_sat

Signed accumulate-and-saturate stage sitting directly downstream of the `sample_mul_mul_*` product pipelines in the inference datapath. It sums a vector of signed products into a dot-product result, saturates it to the layer output width, and presents it on a valid/ready output. It also owns the multiplier's `ce` so that output backpressure freezes the multiplier and accumulator together. It tracks the multiplier's fixed latency with an internal valid/last delay line, so upstream only tags operands, never products.

## Interface
- `DIN_WIDTH`, 11: product width from the multiplier (signed, already truncated).
- `ACC_WIDTH`, 24: internal accumulator width. Must be ≥ DIN_WIDTH + clog2(N_TERMS).
- `DOUT_WIDTH`, 12: saturated result width (signed).
- `N_TERMS`, 16: maximum terms per vector; range 1..256.
- `MUL_LATENCY`, 2: cycles from operand sampling to product available; ≥ 1.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operand pair presented to the multiplier this cycle.
- `in_last`  in  1  qualifies `in_valid`; marks the final term of a vector.
- `din`  in  DIN_WIDTH  product from the multiplier `dout`.
- `ce_out`  out  1  drives the multiplier `ce`; doubles as upstream ready.
- `dout`  out  DOUT_WIDTH  saturated dot-product result.
- `dout_valid`  out  1  `dout` holds an unconsumed result.
- `dout_ready`  in  1  downstream accepts `dout`.
- `overflow`  out  1  current `dout` was clipped.
- `len_err`  out  1  current `dout` was force-closed at N_TERMS without `in_last`.

## Operation
- `ce_out = ~dout_valid | dout_ready`. This is combinational from `dout_ready` and is the only combinational output.
- While `ce_out` is low, the delay line, accumulator and FSM hold. Upstream must hold operands and `in_valid`/`in_last` steady.
- Delay line: MUL_LATENCY stages of {valid, last} advance only when `ce_out` is high. The tail stage is `t_valid`/`t_last`, which is aligned with `din`.
- FSM states:
  - S_IDLE: when `t_valid`, set acc = sext(din) and cnt = 1, then go to S_ACC.
  - S_ACC: when `t_valid`, set acc = acc + sext(din) and cnt = cnt + 1.
  - In either state, a term closes the vector when `t_last` is set or the updated cnt equals N_TERMS. On close, go to S_IDLE.
  - A single-term vector (`t_last` in S_IDLE) closes immediately.
- On close, the final sum (including the closing term) is saturated to [−2^(DOUT_WIDTH−1), 2^(DOUT_WIDTH−1)−1] and written to `dout`. The same edge sets `dout_valid`; sets `overflow` if clipped; sets `len_err` if the close came from the count and `t_last` was 0.
- Output register:
  - Cleared (`dout_valid` = 0) on `dout_valid & dout_ready`, unless a new close occurs on the same edge. In that case the new result loads and `dout_valid` stays 1.
  - When `dout_valid` is 1, `dout_ready` is 0, and a close is pending in the tail, the close cannot occur because `ce_out` is low. There is never overrun.
- Reset: the partial sum is discarded. FSM goes to S_IDLE, cnt = 0, delay line cleared.

## Timing
- Reset values: `dout` = 0, `dout_valid` = 0, `overflow` = 0, `len_err` = 0, acc = 0, cnt = 0, all delay stages 0. `ce_out` = 1 after reset.
- Latency: final operands sampled at edge t (with `ce_out` = 1) produce `dout_valid` = 1 after edge t + MUL_LATENCY, assuming no stall. Each stalled cycle adds one cycle.
- Throughput: one term per cycle. Back-to-back vectors need no bubble: the term after a close starts a new vector in S_IDLE.
- `dout`, `overflow` and `len_err` are stable while `dout_valid & ~dout_ready`.
- Reset asserted mid-vector or with `dout_valid` high takes effect on the next edge, with no output handshake.

## Structure
- Package `sample_acc_pkg`:
  - FSM state enum {S_IDLE, S_ACC}.
  - Default width constants.
  - A pure `sat` function (ACC_WIDTH → DOUT_WIDTH, returns value plus clip flag).
- Sub-module `sample_acc_vld_dly`: parameterised MUL_LATENCY shift register of {valid, last} with enable and synchronous active-low clear.
- Top-level contents: FSM, acc/cnt, output register, `ce_out`.

## Test plan
- Sequence [3, −5, 7, 10], last on the 4th term, `dout_ready` = 1 → `dout` = 15, `overflow` = 0, `dout_valid` exactly MUL_LATENCY cycles after the last operand edge.
- 16 × 1023, last on the 16th term → `dout` = 2047, `overflow` = 1. Then 16 × −1024 → `dout` = −2048, `overflow` = 1.
- 20 terms of 1 with no `in_last` → first result `dout` = 16 with `len_err` = 1. Next result covers 4 terms and `in_last` → `dout` = 4 with `len_err` = 0.
- Hold `dout_ready` = 0 for 5 cycles with a second vector in flight → `ce_out` low, `dout` stable. On release, the second result follows one cycle after acceptance with no lost or duplicated term.
- Single-term vectors back-to-back [9], [−2], `dout_ready` = 1 → two consecutive `dout_valid` cycles carrying 9 then −2.
- Assert `reset` = 0 after 3 terms of a vector, then send [4] with last → `dout` = 4 (partial sum discarded) and all outputs 0 during reset.
